mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (unified instruction/data memory) between the core's data port (loads/stores) and its instruction-fetch port.
- Fixed priority to data, with a bounded-starvation override for fetch; one grant per cycle.
- Tracks outstanding read ownership so each 1-cycle-latency read response returns to the correct requester.
- Sits between the core (and its stall logic) and the memory macro.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter and the core's store path.
// Holds the response-owner encoding, store strobe patterns and default RAM size.
package mem_pkg;

  localparam int DEFAULT_ADDR_W = 14;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'b00,
    RSP_DATA  = 2'b01,
    RSP_INSTR = 2'b10
  } rsp_own_t;

  // Base (lane 0) strobes for sb/sh/sw; the core shifts them by the byte offset.
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between data and fetch ports.
// Data has priority unless fetch has been starved MAX_STARVE cycles in a row.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int MAX_STARVE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  // Handshake: a requester raises req with stable fields and keeps them until the
  // cycle gnt is high; that cycle is the transfer. Reads answer with rvalid one
  // cycle later; stores produce no response.

  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_next;
  rsp_own_t   rsp_own;
  rsp_own_t   rsp_own_next;
  logic       fetch_prio;

  assign fetch_prio = i_req & (starve_cnt == STARVE_LIMIT);
  assign d_gnt      = reset_n & d_req & ~fetch_prio;
  assign i_gnt      = reset_n & i_req & (~d_req | fetch_prio);

  always_comb begin
    m_en    = 1'b0;
    m_we    = 4'b0000;
    m_addr  = d_addr[ADDR_W+1:2];
    m_wdata = d_wdata;
    if (d_gnt) begin
      m_en = 1'b1;
      m_we = d_we ? d_wstrb : 4'b0000;
    end else if (i_gnt) begin
      m_en   = 1'b1;
      m_addr = i_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!i_req || i_gnt) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  always_comb begin
    rsp_own_next = RSP_NONE;
    if (d_gnt && !d_we) begin
      rsp_own_next = RSP_DATA;
    end else if (i_gnt) begin
      rsp_own_next = RSP_INSTR;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
      rsp_own    <= RSP_NONE;
    end else begin
      starve_cnt <= starve_cnt_next;
      rsp_own    <= rsp_own_next;
    end
  end

  assign d_rvalid = (rsp_own == RSP_DATA);
  assign i_rvalid = (rsp_own == RSP_INSTR);
  assign d_rdata  = d_rvalid ? m_rdata : 32'h0;
  assign i_rdata  = i_rvalid ? m_rdata : 32'h0;

  // Byte offset and address bits above the RAM size are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_addr[31:ADDR_W+2], d_addr[1:0],
                              i_addr[31:ADDR_W+2], i_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM behind it.
// Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 14;

  logic              clock;
  logic              reset_n;
  logic              d_req, d_we;
  logic [31:0]       d_addr, d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt, i_rvalid;
  logic [31:0]       i_rdata;
  logic              m_en;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  int tests_run;
  int tests_failed;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model; the preload port lets the bench seed words while the arbiter is idle.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;

  always @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (m_en) begin
      for (int b = 0; b < 4; b++) begin
        if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end
      m_rdata <= mem[m_addr];
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    i_req = 0; i_addr = 0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] v);
    load_en = 1; load_addr = a; load_data = v;
    next_cycle();
    load_en = 0;
  endtask

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_failed++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // tests
  task automatic test_reset();
    reset_n = 0;
    d_req = 1; d_we = 0; d_addr = 32'h40; i_req = 1; i_addr = 32'h8;
    @(negedge clock);
    tests_run++; if (d_gnt !== 1'b0) fail_line("reset_d_gnt", 32'(d_gnt), 0);
    tests_run++; if (i_gnt !== 1'b0) fail_line("reset_i_gnt", 32'(i_gnt), 0);
    tests_run++; if (m_en !== 1'b0) fail_line("reset_m_en", 32'(m_en), 0);
    next_cycle();
    @(negedge clock);
    tests_run++; if (d_rvalid !== 1'b0) fail_line("reset_d_rvalid", 32'(d_rvalid), 0);
    tests_run++; if (i_rvalid !== 1'b0) fail_line("reset_i_rvalid", 32'(i_rvalid), 0);
    idle_inputs();
    next_cycle();
    reset_n = 1;
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        i_req = 1; i_addr = 32'(4 * k);
      end else begin
        i_req = 0;
      end
      @(negedge clock);
      if (k < 3) begin
        tests_run++; if (i_gnt !== 1'b1) fail_line($sformatf("fetch_gnt_%0d", k), 32'(i_gnt), 1);
        tests_run++; if (m_addr !== ADDR_W'(k)) fail_line($sformatf("fetch_maddr_%0d", k), 32'(m_addr), k);
        tests_run++; if (m_we !== 4'b0000) fail_line($sformatf("fetch_mwe_%0d", k), 32'(m_we), 0);
      end
      if (k > 0) begin
        tests_run++; if (i_rvalid !== 1'b1) fail_line($sformatf("fetch_rvalid_%0d", k-1), 32'(i_rvalid), 1);
        tests_run++;
        if (i_rdata !== 32'hA000_0000 + 32'(k - 1))
          fail_line($sformatf("fetch_rdata_%0d", k-1), i_rdata, 32'hA000_0000 + 32'(k - 1));
      end
      tests_run++; if (d_rvalid !== 1'b0) fail_line($sformatf("fetch_d_rvalid_%0d", k), 32'(d_rvalid), 0);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_store_load();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wstrb = 4'b0011; d_wdata = 32'hAAAA_BBBB;
    @(negedge clock);
    tests_run++; if (d_gnt !== 1'b1) fail_line("store_gnt", 32'(d_gnt), 1);
    tests_run++; if (m_we !== 4'b0011) fail_line("store_mwe", 32'(m_we), 32'b0011);
    tests_run++; if (m_addr !== ADDR_W'(14'h40)) fail_line("store_maddr", 32'(m_addr), 32'h40);
    tests_run++; if (m_wdata !== 32'hAAAA_BBBB) fail_line("store_mwdata", m_wdata, 32'hAAAA_BBBB);
    next_cycle();
    d_we = 0; d_wstrb = 4'b1111;
    @(negedge clock);
    tests_run++; if (d_gnt !== 1'b1) fail_line("load_gnt", 32'(d_gnt), 1);
    tests_run++; if (m_we !== 4'b0000) fail_line("load_mwe", 32'(m_we), 0);
    tests_run++; if (d_rvalid !== 1'b0) fail_line("store_no_rvalid", 32'(d_rvalid), 0);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    tests_run++; if (d_rvalid !== 1'b1) fail_line("load_rvalid", 32'(d_rvalid), 1);
    tests_run++; if (d_rdata !== 32'h1111_BBBB) fail_line("load_rdata", d_rdata, 32'h1111_BBBB);
    tests_run++; if (i_rvalid !== 1'b0) fail_line("load_i_rvalid", 32'(i_rvalid), 0);
    next_cycle();
  endtask

  task automatic test_contention();
    logic [9:0] exp_i;
    exp_i = 10'b1000010000; // bit k set where cycle k goes to fetch
    d_req = 1; d_we = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      tests_run++;
      if (i_gnt !== exp_i[k] || d_gnt !== ~exp_i[k])
        fail_line($sformatf("contend_cycle_%0d{d,i}", k), {30'b0, d_gnt, i_gnt}, {30'b0, ~exp_i[k], exp_i[k]});
      tests_run++;
      if (dut.starve_cnt > 4'd4) fail_line($sformatf("contend_starve_%0d", k), 32'(dut.starve_cnt), 4);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_interleaved();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    @(negedge clock);
    tests_run++; if (d_gnt !== 1'b1) fail_line("inter_d_gnt", 32'(d_gnt), 1);
    next_cycle();
    idle_inputs();
    i_req = 1; i_addr = 32'h10;
    @(negedge clock);
    tests_run++; if (i_gnt !== 1'b1) fail_line("inter_i_gnt", 32'(i_gnt), 1);
    tests_run++; if (d_rvalid !== 1'b1) fail_line("inter_d_rvalid", 32'(d_rvalid), 1);
    tests_run++; if (d_rdata !== 32'hDDDD_0080) fail_line("inter_d_rdata", d_rdata, 32'hDDDD_0080);
    tests_run++; if (i_rvalid !== 1'b0) fail_line("inter_i_rvalid_early", 32'(i_rvalid), 0);
    tests_run++; if (i_rdata !== 32'h0) fail_line("inter_i_rdata_early", i_rdata, 0);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    tests_run++; if (i_rvalid !== 1'b1) fail_line("inter_i_rvalid", 32'(i_rvalid), 1);
    tests_run++; if (i_rdata !== 32'hA000_0004) fail_line("inter_i_rdata", i_rdata, 32'hA000_0004);
    tests_run++; if (d_rvalid !== 1'b0) fail_line("inter_d_rvalid_late", 32'(d_rvalid), 0);
    tests_run++; if (d_rdata !== 32'h0) fail_line("inter_d_rdata_late", d_rdata, 0);
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    d_req = 1; d_we = 0; d_addr = 32'h200; i_req = 1; i_addr = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    tests_run++; if (d_gnt !== 1'b1) fail_line("midrst_d_gnt", 32'(d_gnt), 1);
    reset_n = 0;
    next_cycle();
    @(negedge clock);
    tests_run++; if (d_rvalid !== 1'b0) fail_line("midrst_d_rvalid", 32'(d_rvalid), 0);
    tests_run++; if (i_rvalid !== 1'b0) fail_line("midrst_i_rvalid", 32'(i_rvalid), 0);
    tests_run++; if (dut.starve_cnt !== 4'd0) fail_line("midrst_starve", 32'(dut.starve_cnt), 0);
    tests_run++; if (m_en !== 1'b0) fail_line("midrst_m_en", 32'(m_en), 0);
    tests_run++; if (i_gnt !== 1'b0) fail_line("midrst_i_gnt", 32'(i_gnt), 0);
    idle_inputs();
    next_cycle();
    reset_n = 1;
    next_cycle();
  endtask

  task automatic test_idle();
    idle_inputs();
    @(negedge clock);
    tests_run++; if (m_en !== 1'b0) fail_line("idle_m_en", 32'(m_en), 0);
    tests_run++; if (m_we !== 4'b0000) fail_line("idle_m_we", 32'(m_we), 0);
    tests_run++; if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0)
      fail_line("idle_rvalid{d,i}", {30'b0, d_rvalid, i_rvalid}, 0);
    tests_run++; if (d_rdata !== 32'h0) fail_line("idle_d_rdata", d_rdata, 0);
    tests_run++; if (i_rdata !== 32'h0) fail_line("idle_i_rdata", i_rdata, 0);
    next_cycle();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    load_en = 0; load_addr = '0; load_data = '0;
    reset_n = 0;
    idle_inputs();
    next_cycle();
    preload(14'h0,  32'hA000_0000);
    preload(14'h1,  32'hA000_0001);
    preload(14'h2,  32'hA000_0002);
    preload(14'h4,  32'hA000_0004);
    preload(14'h40, 32'h1111_2222);
    preload(14'h80, 32'hDDDD_0080);
    test_reset();
    test_fetch_only();
    test_store_load();
    test_contention();
    test_interleaved();
    test_reset_mid_op();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
